combination_engine: RTL and testbench

COMBINATION_ENGINE -- requirements
Module: combination_engine

---
 rtl/combination_engine.sv | 147 ++++++++++++++
 tb/tb_combination_engine.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/combination_engine.sv
// Accumulates FM_WM rows along COO edges into an internal ADJ_FM_WM array (A, A+A^T, optionally +I).
// Define COMB_SATURATE_EN to clamp element adds on signed overflow instead of wrapping.
module combination_engine #(
  parameter int FEATURE_ROWS   = 6,
  parameter int WEIGHT_COLS    = 3,
  parameter int DOT_PROD_WIDTH = 16,
  parameter int NUM_EDGES      = 6,
  parameter int COO_BW         = 3,
  parameter int UNDIRECTED     = 1,
  parameter int SELF_LOOP      = 0,
  localparam int ROW_AW  = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1,
  localparam int EDGE_AW = (NUM_EDGES > 1) ? $clog2(NUM_EDGES) : 1,
  localparam int ROW_W   = WEIGHT_COLS * DOT_PROD_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [2*COO_BW-1:0] coo_in,
  input  logic [ROW_W-1:0]    fm_wm_row_data,
  input  logic [ROW_AW-1:0]   read_row,
  output logic [EDGE_AW-1:0]  coo_address,
  output logic [ROW_AW-1:0]   read_fm_wm_row,
  output logic                busy,
  output logic                done_comb,
  output logic                bad_edge,
  output logic [ROW_W-1:0]    adj_fm_wm_row
);

  typedef enum logic [2:0] {IDLE, CLEAR, SELF, FWD, REV, DONE} state_t;

  localparam int W = DOT_PROD_WIDTH;
  localparam logic [ROW_AW-1:0]  LAST_ROW  = ROW_AW'(FEATURE_ROWS - 1);
  localparam logic [EDGE_AW-1:0] LAST_EDGE = EDGE_AW'(NUM_EDGES - 1);
`ifdef COMB_SATURATE_EN
  localparam logic signed [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};
`endif

  state_t              state, next_state;
  logic [ROW_W-1:0]    mem [FEATURE_ROWS];
  logic [ROW_AW-1:0]   row_cnt;
  logic [COO_BW-1:0]   src, dst;
  logic [ROW_AW-1:0]   src_idx, dst_idx, wr_idx;
  logic                edge_ok, wr_en, clear, advance, set_bad;

  assign src     = coo_in[2*COO_BW-1:COO_BW];
  assign dst     = coo_in[COO_BW-1:0];
  assign src_idx = ROW_AW'(src - COO_BW'(1));
  assign dst_idx = ROW_AW'(dst - COO_BW'(1));
  assign edge_ok = (src != '0) && (dst != '0) &&
                   (int'(src) <= FEATURE_ROWS) && (int'(dst) <= FEATURE_ROWS);

  function automatic logic [ROW_W-1:0] add_row(input logic [ROW_W-1:0] a,
                                               input logic [ROW_W-1:0] b);
    logic [ROW_W-1:0]    r;
    logic signed [W-1:0] x, y, s;
    r = '0;
    for (int unsigned j = 0; j < WEIGHT_COLS; j++) begin
      x = a[j*W +: W];
      y = b[j*W +: W];
      s = x + y;
`ifdef COMB_SATURATE_EN
      if ((x[W-1] == y[W-1]) && (s[W-1] != x[W-1]))
        s = x[W-1] ? SAT_MIN : SAT_MAX;
`endif
      r[j*W +: W] = s;
    end
    return r;
  endfunction

  always_comb begin
    next_state     = state;
    read_fm_wm_row = '0;
    wr_en          = 1'b0;
    wr_idx         = '0;
    clear          = 1'b0;
    advance        = 1'b0;
    set_bad        = 1'b0;
    case (state)
      IDLE, DONE: if (start) next_state = CLEAR;
      CLEAR: begin
        clear      = 1'b1;
        next_state = (SELF_LOOP != 0) ? SELF : FWD;
      end
      SELF: begin
        read_fm_wm_row = row_cnt;
        wr_en          = 1'b1;
        wr_idx         = row_cnt;
        if (row_cnt == LAST_ROW) next_state = FWD;
      end
      FWD: begin
        if (!edge_ok) begin
          set_bad = 1'b1;
          advance = 1'b1;
        end else begin
          read_fm_wm_row = src_idx;
          wr_en          = 1'b1;
          wr_idx         = dst_idx;
          // A self-edge would double-count under A+A^T, so it stays single.
          if ((UNDIRECTED != 0) && (src != dst)) next_state = REV;
          else advance = 1'b1;
        end
      end
      REV: begin
        read_fm_wm_row = dst_idx;
        wr_en          = 1'b1;
        wr_idx         = src_idx;
        advance        = 1'b1;
      end
      default: next_state = IDLE;
    endcase
    if (advance) next_state = (coo_address == LAST_EDGE) ? DONE : FWD;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      coo_address <= '0;
      row_cnt     <= '0;
      bad_edge    <= 1'b0;
      for (int unsigned i = 0; i < FEATURE_ROWS; i++) mem[i] <= '0;
    end else begin
      state <= next_state;
      if (clear) begin
        coo_address <= '0;
        row_cnt     <= '0;
        bad_edge    <= 1'b0;
        for (int unsigned i = 0; i < FEATURE_ROWS; i++) mem[i] <= '0;
      end else begin
        if (wr_en) mem[wr_idx] <= add_row(mem[wr_idx], fm_wm_row_data);
        if (state == SELF) row_cnt <= row_cnt + ROW_AW'(1);
        if (set_bad) bad_edge <= 1'b1;
        if (advance)
          coo_address <= (coo_address == LAST_EDGE) ? '0 : coo_address + EDGE_AW'(1);
      end
    end
  end

  assign busy      = (state == CLEAR) || (state == SELF) || (state == FWD) || (state == REV);
  assign done_comb = (state == DONE);

  always_comb begin
    adj_fm_wm_row = '0;
    if ((state == DONE) && (int'(read_row) < FEATURE_ROWS)) adj_fm_wm_row = mem[read_row];
  end

endmodule

// File: tb/tb_combination_engine.sv
// Bench for combination_engine: undirected, directed and self-loop instances share one
// FM_WM/COO source and are checked against an edge-list accumulation model.
`timescale 1ns/1ps
module tb_combination_engine;

  typedef logic [7:0][47:0] rows_t;
  typedef struct {
    string           name;
    logic [5:0][5:0] e;
    int              kind;
    int              lat;
    bit              bad;
  } vec_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start;
  logic [2:0]  read_row;
  logic [47:0] fm_rows [8];
  logic [5:0]  coo_mem [8];

  logic [2:0]  ca_u, ca_d, ca_s, rf_u, rf_d, rf_s;
  logic        busy_u, busy_d, busy_s, done_u, done_d, done_s, bad_u, bad_d, bad_s;
  logic [47:0] adj_u, adj_d, adj_s, fm_u, fm_d, fm_s;
  logic [5:0]  coo_u, coo_d, coo_s;

  assign coo_u = coo_mem[ca_u];
  assign coo_d = coo_mem[ca_d];
  assign coo_s = coo_mem[ca_s];
  assign fm_u  = fm_rows[rf_u];
  assign fm_d  = fm_rows[rf_d];
  assign fm_s  = fm_rows[rf_s];

  combination_engine #(.UNDIRECTED(1), .SELF_LOOP(0)) u_und (
    .clk(clk), .reset(reset), .start(start), .coo_in(coo_u), .fm_wm_row_data(fm_u),
    .read_row(read_row), .coo_address(ca_u), .read_fm_wm_row(rf_u), .busy(busy_u),
    .done_comb(done_u), .bad_edge(bad_u), .adj_fm_wm_row(adj_u));

  combination_engine #(.UNDIRECTED(0), .SELF_LOOP(0)) u_dir (
    .clk(clk), .reset(reset), .start(start), .coo_in(coo_d), .fm_wm_row_data(fm_d),
    .read_row(read_row), .coo_address(ca_d), .read_fm_wm_row(rf_d), .busy(busy_d),
    .done_comb(done_d), .bad_edge(bad_d), .adj_fm_wm_row(adj_d));

  combination_engine #(.UNDIRECTED(1), .SELF_LOOP(1)) u_self (
    .clk(clk), .reset(reset), .start(start), .coo_in(coo_s), .fm_wm_row_data(fm_s),
    .read_row(read_row), .coo_address(ca_s), .read_fm_wm_row(rf_s), .busy(busy_s),
    .done_comb(done_s), .bad_edge(bad_s), .adj_fm_wm_row(adj_s));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic bit valid_edge(input logic [5:0] c);
    return (c[5:3] != 0) && (c[2:0] != 0) && (c[5:3] <= 6) && (c[2:0] <= 6);
  endfunction

  function automatic logic [47:0] add_rows(input logic [47:0] a, input logic [47:0] b);
    logic [47:0] r;
    for (int j = 0; j < 3; j++) begin
      int s;
      s = int'($signed(a[j*16 +: 16])) + int'($signed(b[j*16 +: 16]));
`ifdef COMB_SATURATE_EN
      if (s > 32767)  s = 32767;
      if (s < -32768) s = -32768;
`endif
      r[j*16 +: 16] = 16'(s);
    end
    return r;
  endfunction

  // ADJ = sum over valid edges of FM[src] into dst, plus FM[dst] into src when undirected.
  function automatic rows_t model_rows(input bit und, input bit sl);
    rows_t r;
    r = '0;
    if (sl) for (int i = 0; i < 6; i++) r[i] = add_rows(r[i], fm_rows[i]);
    for (int e = 0; e < 6; e++) begin
      int s, d;
      s = int'(coo_mem[e][5:3]);
      d = int'(coo_mem[e][2:0]);
      if (valid_edge(coo_mem[e])) begin
        r[d-1] = add_rows(r[d-1], fm_rows[s-1]);
        if (und && s != d) r[s-1] = add_rows(r[s-1], fm_rows[d-1]);
      end
    end
    return r;
  endfunction

  function automatic int model_lat(input bit und, input bit sl);
    int n;
    n = 2 + (sl ? 6 : 0);
    for (int e = 0; e < 6; e++) begin
      n += 1;
      if (und && valid_edge(coo_mem[e]) && coo_mem[e][5:3] != coo_mem[e][2:0]) n += 1;
    end
    return n;
  endfunction

  function automatic bit model_bad();
    bit b;
    b = 1'b0;
    for (int e = 0; e < 6; e++) if (!valid_edge(coo_mem[e])) b = 1'b1;
    return b;
  endfunction

  task automatic load_fm(input int kind);
    for (int i = 0; i < 8; i++) fm_rows[i] = '0;
    for (int i = 0; i < 6; i++) begin
      case (kind)
        0:       fm_rows[i] = {3{16'(i + 1)}};
        2:       fm_rows[i] = (i < 2) ? {3{16'h7fff}} : {3{16'(i + 1)}};
        default: fm_rows[i] = {16'($urandom), 16'($urandom), 16'($urandom)};
      endcase
    end
  endtask

  task automatic load_edges(input logic [5:0][5:0] e);
    for (int i = 0; i < 8; i++) coo_mem[i] = (i < 6) ? e[i] : 6'd0;
  endtask

  task automatic do_run(input string nm, input int exp_lat_u, input bit exp_bad_u,
                        input int restart_at);
    int    lat [3];
    rows_t eu, ed, es;
    eu  = model_rows(1'b1, 1'b0);
    ed  = model_rows(1'b0, 1'b0);
    es  = model_rows(1'b1, 1'b1);
    lat = '{0, 0, 0};
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk);
      #1;
      start = (c == restart_at);
      if (c == 2) begin
        chk({nm, ".busy"}, {47'd0, busy_u}, 48'd1);
        chk({nm, ".adj_zero_busy"}, adj_u, 48'd0);
      end
      if (done_u && lat[0] == 0) lat[0] = c;
      if (done_d && lat[1] == 0) lat[1] = c;
      if (done_s && lat[2] == 0) lat[2] = c;
      if (lat[0] != 0 && lat[1] != 0 && lat[2] != 0) break;
    end
    start = 1'b0;
    chk({nm, ".lat_und"},  48'(lat[0]), 48'(exp_lat_u));
    chk({nm, ".lat_dir"},  48'(lat[1]), 48'(model_lat(1'b0, 1'b0)));
    chk({nm, ".lat_self"}, 48'(lat[2]), 48'(model_lat(1'b1, 1'b1)));
    for (int r = 0; r < 6; r++) begin
      read_row = 3'(r);
      #1;
      chk($sformatf("%s.row%0d.und", nm, r),  adj_u, eu[r]);
      chk($sformatf("%s.row%0d.dir", nm, r),  adj_d, ed[r]);
      chk($sformatf("%s.row%0d.self", nm, r), adj_s, es[r]);
    end
    chk({nm, ".bad_und"},  {47'd0, bad_u}, {47'd0, exp_bad_u});
    chk({nm, ".bad_dir"},  {47'd0, bad_d}, {47'd0, model_bad()});
    chk({nm, ".bad_self"}, {47'd0, bad_s}, {47'd0, model_bad()});
    chk({nm, ".coo_addr_done"}, {45'd0, ca_u}, 48'd0);
    chk({nm, ".rd_row_done"},   {45'd0, rf_u}, 48'd0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, ".busy"},  {47'd0, busy_u}, 48'd0);
    chk({nm, ".done"},  {47'd0, done_u}, 48'd0);
    chk({nm, ".bad"},   {47'd0, bad_u},  48'd0);
    chk({nm, ".coo"},   {45'd0, ca_u},   48'd0);
    chk({nm, ".rdrow"}, {45'd0, rf_u},   48'd0);
    chk({nm, ".adj"},   adj_u,           48'd0);
    chk({nm, ".done_dir"}, {47'd0, done_d}, 48'd0);
  endtask

  vec_t        vecs [3];
  logic [15:0] sat_exp;
  int          dir_ring [6];
  bit          found;

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    read_row = '0;
    vecs[0] = '{"ring",    {6'o61, 6'o56, 6'o45, 6'o34, 6'o23, 6'o12}, 0, 14, 1'b0};
    vecs[1] = '{"loopbad", {6'o56, 6'o71, 6'o24, 6'o11, 6'o02, 6'o33}, 0, 10, 1'b1};
    vecs[2] = '{"sat",     {6'o65, 6'o56, 6'o44, 6'o44, 6'o23, 6'o13}, 2, 12, 1'b0};
    dir_ring = '{6, 1, 2, 3, 4, 5};
`ifdef COMB_SATURATE_EN
    sat_exp = 16'h7fff;
`else
    sat_exp = 16'hfffe;
`endif
    load_fm(0);
    load_edges(vecs[0].e);

    #2;
    chk_all_zero("reset_t0");
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset_held");

    for (int v = 0; v < 3; v++) begin
      load_fm(vecs[v].kind);
      load_edges(vecs[v].e);
      do_run(vecs[v].name, vecs[v].lat, vecs[v].bad, 0);
      case (v)
        0: for (int r = 0; r < 6; r++) begin
             read_row = 3'(r);
             #1;
             chk($sformatf("ring.dir_row%0d", r), adj_d, {3{16'(dir_ring[r])}});
           end
        1: begin
             read_row = 3'd2;
             #1;
             chk("loopbad.self_edge_once", adj_u, {3{16'd3}});
           end
        default: begin
             read_row = 3'd2;
             #1;
             chk("sat.row2_elem0", {32'd0, adj_u[15:0]}, {32'd0, sat_exp});
           end
      endcase
    end

    // Reset while u_und is in REV of edge 3 (edge (4,5): REV reads FM row 4).
    load_fm(0);
    load_edges(vecs[0].e);
    found = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (busy_u && ca_u == 3'd3 && rf_u == 3'd4) begin
        found = 1'b1;
        break;
      end
    end
    chk("mid_reset.reached_rev3", {47'd0, found}, 48'd1);
    reset = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    do_run("after_reset", 14, 1'b0, 0);

    for (int i = 0; i < 20; i++) begin
      logic [5:0][5:0] e;
      for (int k = 0; k < 6; k++) begin
        if ($urandom_range(0, 9) == 0) e[k] = 6'($urandom_range(0, 63));
        else e[k] = {3'($urandom_range(1, 6)), 3'($urandom_range(1, 6))};
      end
      load_fm(1);
      load_edges(e);
      do_run($sformatf("rand%0d", i), model_lat(1'b1, 1'b0), model_bad(),
             (i == 0) ? 3 : ((i == 1) ? 5 : 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
